atm_keypad_frontend: RTL and testbench
======================================

ATM_KEYPAD_FRONTEND -- requirements
Module: atm_keypad_frontend

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port key_valid, input, 1 bit: key_code is valid this cycle, one key per cycle.
REQ-004 SHALL have port key_code, input, 4 bits: 0-9 digit, 0xA ENTER, 0xB CLEAR, 0xC CANCEL, 0xD-0xF illegal.
REQ-005 SHALL have port req_valid, output, 1 bit: request payload valid toward the ATM controller.
REQ-006 SHALL have port req_ready, input, 1 bit: controller accepts the request.
REQ-007 SHALL have port acc_number, output, 12 bits: customer account number.
REQ-008 SHALL have port pin, output, 4 bits: customer PIN digit.
REQ-009 SHALL have port menu_option, output, 3 bits: selected menu code.
REQ-010 SHALL have port destination_acc, output, 12 bits: transfer target account.
REQ-011 SHALL have port amount, output, 11 bits: withdraw or transfer amount.
REQ-012 SHALL have port exit, output, 1 bit: one-cycle session-abort pulse.
REQ-013 SHALL have port key_err, output, 1 bit: one-cycle pulse on each rejected key.

Function
REQ-014 SHALL implement states S_ACC, S_PIN, S_MENU, S_DEST, S_AMT, S_ISSUE; keys are sampled only when key_valid=1 and take effect at the next clk edge.
REQ-015 SHALL hold a 14-bit decimal accumulator and a 3-bit digit count: each digit sets acc = acc*10 + d and count+1; a 5th digit in S_ACC/S_DEST/S_AMT is ignored and pulses key_err.
REQ-016 SHALL, on CLEAR in any entry state, zero the accumulator and count, stay in the state, and not pulse key_err.
REQ-017 SHALL, on ENTER in S_ACC, latch acc_number and go to S_PIN if count>=1 and acc<=4095; otherwise pulse key_err, clear the accumulator and stay.
REQ-018 SHALL accept exactly one digit in S_PIN; ENTER with count=1 latches pin and goes to S_MENU; other ENTERs or a 2nd digit pulse key_err.
REQ-019 SHALL accept exactly one digit 0-7 in S_MENU; digits 8-9 pulse key_err and are discarded.
REQ-020 SHALL, on valid ENTER in S_MENU, latch menu_option and go to S_AMT for 4/5, S_DEST for 6, and S_ISSUE for all other values.
REQ-021 SHALL, in S_DEST, follow the REQ-017 rules, latch destination_acc on valid ENTER, and go to S_AMT.
REQ-022 SHALL, in S_AMT, accept ENTER only if count>=1 and acc<=2047, latch amount[10:0], and go to S_ISSUE; otherwise pulse key_err and clear.
REQ-023 SHALL assert req_valid from the first cycle in S_ISSUE; req_valid and all payload outputs SHALL stay stable until a cycle with req_valid=1 and req_ready=1.
REQ-024 SHALL, on that handshake edge, drop req_valid next cycle and return to S_MENU, keeping acc_number and pin latched.
REQ-025 SHALL ignore non-CANCEL keys in S_ISSUE and pulse key_err for them.
REQ-026 SHALL pulse key_err for illegal codes 0xD-0xF in any state and leave the state unchanged.
REQ-027 SHALL, on CANCEL in any state, pulse exit for one cycle, clear all payload outputs and the accumulator, deassert req_valid next cycle, and go to S_ACC.
REQ-028 SHALL give CANCEL priority if it coincides with req_ready in S_ISSUE: the handshake counts as complete, exit pulses, and the next state is S_ACC.
REQ-029 SHALL clear the accumulator and count on every state transition.

Reset
REQ-030 SHALL, while rst_n=0, force state S_ACC, accumulator and count 0, and all outputs (req_valid, acc_number, pin, menu_option, destination_acc, amount, exit, key_err) to 0 without waiting for clk.
REQ-031 SHALL, on reset asserted mid-handshake, drop req_valid immediately, with no exit pulse.

Verification
REQ-032 SHALL pass: keys 2,7,4,9,ENTER,3,ENTER,3,ENTER; req_ready=1 -> acc_number=2749, pin=3, menu_option=3, req_valid high exactly until the handshake, then S_MENU.
REQ-033 SHALL pass: after login, keys 6,ENTER,2,1,7,5,ENTER,1,0,0,ENTER, with req_ready held 0 for 5 cycles -> destination_acc=2175, amount=100, outputs stable for 5 cycles, one handshake.
REQ-034 SHALL pass: in S_ACC, keys 9,9,9,9,ENTER -> key_err pulse, acc_number stays 0, state S_ACC; then 9,9,9,9,9 -> key_err on the 5th digit.
REQ-035 SHALL pass: in S_AMT, keys 2,0,4,8,ENTER -> key_err; then 2,0,4,7,ENTER -> amount=2047.
REQ-036 SHALL pass: CANCEL in the same cycle as req_ready=1 during S_ISSUE -> one exit pulse, all payload outputs 0, state S_ACC.
REQ-037 SHALL pass: rst_n=0 asynchronously mid-S_ISSUE -> req_valid=0 before the next clk edge, all outputs 0, no exit pulse.

Source files
------------

// File: rtl/atm_keypad_frontend.sv
// ATM keypad front end: gathers decimal keypad entry into account, PIN, menu,
// destination and amount fields, then issues one request with a valid/ready handshake.
module atm_keypad_frontend (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [11:0] acc_number,
    output logic [3:0]  pin,
    output logic [2:0]  menu_option,
    output logic [11:0] destination_acc,
    output logic [10:0] amount,
    output logic        exit,
    output logic        key_err
);

    typedef enum logic [2:0] {S_ACC, S_PIN, S_MENU, S_DEST, S_AMT, S_ISSUE} state_t;

    localparam logic [3:0] K_ENTER  = 4'hA;
    localparam logic [3:0] K_CLEAR  = 4'hB;
    localparam logic [3:0] K_CANCEL = 4'hC;

    state_t      state_reg;
    logic [13:0] acc_reg;
    logic [2:0]  cnt_reg;

    logic [13:0] acc_next;
    logic        acc_ok;
    logic        amt_ok;

    // Four digits at most reach the accumulator, so 9999 is the largest value it holds.
    assign acc_next = acc_reg * 14'd10 + {10'd0, key_code};
    assign acc_ok   = (cnt_reg != 3'd0) && (acc_reg <= 14'd4095);
    assign amt_ok   = (cnt_reg != 3'd0) && (acc_reg <= 14'd2047);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_ACC;
            acc_reg         <= '0;
            cnt_reg         <= '0;
            req_valid       <= 1'b0;
            acc_number      <= '0;
            pin             <= '0;
            menu_option     <= '0;
            destination_acc <= '0;
            amount          <= '0;
            exit            <= 1'b0;
            key_err         <= 1'b0;
        end else begin
            exit    <= 1'b0;
            key_err <= 1'b0;

            if (req_valid && req_ready) begin
                req_valid <= 1'b0;
                state_reg <= S_MENU;
                acc_reg   <= '0;
                cnt_reg   <= '0;
            end

            // CANCEL is decoded last so it overrides a coincident handshake.
            if (key_valid) begin
                if (key_code == K_CANCEL) begin
                    exit            <= 1'b1;
                    req_valid       <= 1'b0;
                    state_reg       <= S_ACC;
                    acc_reg         <= '0;
                    cnt_reg         <= '0;
                    acc_number      <= '0;
                    pin             <= '0;
                    menu_option     <= '0;
                    destination_acc <= '0;
                    amount          <= '0;
                end else if (key_code > K_CANCEL || state_reg == S_ISSUE) begin
                    key_err <= 1'b1;
                end else if (key_code == K_CLEAR) begin
                    acc_reg <= '0;
                    cnt_reg <= '0;
                end else if (key_code == K_ENTER) begin
                    acc_reg <= '0;
                    cnt_reg <= '0;
                    case (state_reg)
                        S_ACC: begin
                            if (acc_ok) begin
                                acc_number <= acc_reg[11:0];
                                state_reg  <= S_PIN;
                            end else begin
                                key_err <= 1'b1;
                            end
                        end
                        S_PIN: begin
                            if (cnt_reg == 3'd1) begin
                                pin       <= acc_reg[3:0];
                                state_reg <= S_MENU;
                            end else begin
                                key_err <= 1'b1;
                                acc_reg <= acc_reg;
                                cnt_reg <= cnt_reg;
                            end
                        end
                        S_MENU: begin
                            if (cnt_reg == 3'd1) begin
                                menu_option <= acc_reg[2:0];
                                case (acc_reg[2:0])
                                    3'd4, 3'd5: state_reg <= S_AMT;
                                    3'd6:       state_reg <= S_DEST;
                                    default: begin
                                        state_reg <= S_ISSUE;
                                        req_valid <= 1'b1;
                                    end
                                endcase
                            end else begin
                                key_err <= 1'b1;
                                acc_reg <= acc_reg;
                                cnt_reg <= cnt_reg;
                            end
                        end
                        S_DEST: begin
                            if (acc_ok) begin
                                destination_acc <= acc_reg[11:0];
                                state_reg       <= S_AMT;
                            end else begin
                                key_err <= 1'b1;
                            end
                        end
                        S_AMT: begin
                            if (amt_ok) begin
                                amount    <= acc_reg[10:0];
                                state_reg <= S_ISSUE;
                                req_valid <= 1'b1;
                            end else begin
                                key_err <= 1'b1;
                            end
                        end
                        default: state_reg <= S_ACC;
                    endcase
                end else begin
                    // Digit: each field has its own admissible digit count.
                    case (state_reg)
                        S_ACC, S_DEST, S_AMT: begin
                            if (cnt_reg == 3'd4) begin
                                key_err <= 1'b1;
                            end else begin
                                acc_reg <= acc_next;
                                cnt_reg <= cnt_reg + 3'd1;
                            end
                        end
                        S_PIN: begin
                            if (cnt_reg != 3'd0) begin
                                key_err <= 1'b1;
                            end else begin
                                acc_reg <= acc_next;
                                cnt_reg <= cnt_reg + 3'd1;
                            end
                        end
                        S_MENU: begin
                            if (cnt_reg != 3'd0 || key_code > 4'd7) begin
                                key_err <= 1'b1;
                            end else begin
                                acc_reg <= acc_next;
                                cnt_reg <= cnt_reg + 3'd1;
                            end
                        end
                        default: key_err <= 1'b1;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Directed bench for atm_keypad_frontend: expected requests are queued as the
// issuing key is driven and compared when the handshake is observed.
module tb_atm_keypad_frontend;

    localparam logic [3:0] K_ENTER  = 4'hA;
    localparam logic [3:0] K_CLEAR  = 4'hB;
    localparam logic [3:0] K_CANCEL = 4'hC;

    typedef struct packed {
        logic [11:0] acc;
        logic [3:0]  pin;
        logic [2:0]  menu;
        logic [11:0] dest;
        logic [10:0] amt;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] acc_number;
    logic [3:0]  pin;
    logic [2:0]  menu_option;
    logic [11:0] destination_acc;
    logic [10:0] amount;
    logic        exit;
    logic        key_err;

    int   n_pass = 0;
    int   n_total = 0;
    int   hs_count = 0;
    int   exit_count = 0;
    txn_t sb[$];
    txn_t exp_txn;

    wire [41:0] payload = {acc_number, pin, menu_option, destination_acc, amount};

    atm_keypad_frontend dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .req_valid(req_valid), .req_ready(req_ready), .acc_number(acc_number),
        .pin(pin), .menu_option(menu_option), .destination_acc(destination_acc),
        .amount(amount), .exit(exit), .key_err(key_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic txn_t mk(input int a, input int p, input int m, input int d, input int amt);
        txn_t t;
        t.acc  = 12'(a);
        t.pin  = 4'(p);
        t.menu = 3'(m);
        t.dest = 12'(d);
        t.amt  = 11'(amt);
        return t;
    endfunction

    // Caller is always at posedge+1; the key is sampled at the next edge.
    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic press_chk(input logic [3:0] k, input logic err_exp);
        press(k);
        chk($sformatf("key_err_after_%0h", k), 64'(key_err), 64'(err_exp));
    endtask

    task automatic wait_hs(input int target);
        for (int i = 0; i < 20 && hs_count < target; i++) @(posedge clk);
        #1;
        chk("hs_count", 64'(hs_count), 64'(target));
    endtask

    // Monitor: the handshake is sampled mid-cycle, before the edge that completes it.
    always @(negedge clk) begin
        if (exit) begin
            exit_count++;
            $display("exit pulse #%0d at %0t", exit_count, $time);
        end
        if (rst_n && req_valid && req_ready) begin
            hs_count++;
            $display("handshake #%0d acc=%0d pin=%0d menu=%0d dest=%0d amt=%0d",
                     hs_count, acc_number, pin, menu_option, destination_acc, amount);
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(hs_count), 64'd0);
            end else begin
                exp_txn = sb.pop_front();
                chk("hs_acc",  64'(acc_number),      64'(exp_txn.acc));
                chk("hs_pin",  64'(pin),             64'(exp_txn.pin));
                chk("hs_menu", 64'(menu_option),     64'(exp_txn.menu));
                chk("hs_dest", 64'(destination_acc), 64'(exp_txn.dest));
                chk("hs_amt",  64'(amount),          64'(exp_txn.amt));
            end
        end
    end

    initial begin
        txn_t held;
        key_valid = 1'b0;
        key_code  = 4'h0;
        req_ready = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        chk("reset_outputs", 64'({req_valid, payload, exit, key_err}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Login and a plain menu-3 request with the controller always ready.
        req_ready = 1'b1;
        press(4'd2); press(4'd7); press(4'd4); press(4'd9); press(K_ENTER);
        chk("acc_latched", 64'(acc_number), 64'd2749);
        press(4'd3); press(K_ENTER);
        chk("pin_latched", 64'(pin), 64'd3);
        press(4'd3);
        sb.push_back(mk(2749, 3, 3, 0, 0));
        press(K_ENTER);
        chk("issue_valid", 64'(req_valid), 64'd1);
        @(posedge clk); #1;
        chk("valid_dropped", 64'(req_valid), 64'd0);
        chk("hs_count_1", 64'(hs_count), 64'd1);
        chk("acc_kept", 64'(acc_number), 64'd2749);
        chk("pin_kept", 64'(pin), 64'd3);
        req_ready = 1'b0;

        // Transfer with a stalled controller.
        press(4'd6); press(K_ENTER);
        press(4'd2); press(4'd1); press(4'd7); press(4'd5); press(K_ENTER);
        chk("dest_latched", 64'(destination_acc), 64'd2175);
        press(4'd1); press(4'd0); press(4'd0);
        held = mk(2749, 3, 6, 2175, 100);
        sb.push_back(held);
        press(K_ENTER);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 64'(req_valid), 64'd1);
            chk("hold_payload", 64'(payload), 64'(held));
            @(posedge clk); #1;
        end
        press_chk(4'd5, 1'b1);
        chk("issue_digit_ignored", 64'(payload), 64'(held));
        req_ready = 1'b1;
        wait_hs(2);
        req_ready = 1'b0;
        chk("valid_dropped_2", 64'(req_valid), 64'd0);

        // Withdraw: amount bound and CLEAR.
        press_chk(4'd8, 1'b1);
        press_chk(4'd4, 1'b0);
        press(K_ENTER);
        press(4'd2); press(4'd0); press(4'd4); press(4'd8);
        press_chk(K_ENTER, 1'b1);
        chk("amount_unchanged", 64'(amount), 64'd100);
        press(4'd9);
        press_chk(K_CLEAR, 1'b0);
        press(4'd2); press(4'd0); press(4'd4); press(4'd7);
        sb.push_back(mk(2749, 3, 4, 2175, 2047));
        press(K_ENTER);
        chk("amount_2047", 64'(amount), 64'd2047);
        chk("issue_valid_3", 64'(req_valid), 64'd1);

        // CANCEL coinciding with req_ready.
        req_ready = 1'b1;
        key_valid = 1'b1;
        key_code  = K_CANCEL;
        @(posedge clk); #1;
        key_valid = 1'b0;
        req_ready = 1'b0;
        chk("cancel_exit", 64'(exit), 64'd1);
        chk("cancel_valid", 64'(req_valid), 64'd0);
        chk("cancel_payload", 64'(payload), 64'd0);
        chk("hs_count_3", 64'(hs_count), 64'd3);
        @(posedge clk); #1;
        chk("exit_one_cycle", 64'(exit), 64'd0);
        chk("exit_count_1", 64'(exit_count), 64'd1);

        // Account range and digit limit in S_ACC.
        press(4'd9); press(4'd9); press(4'd9); press(4'd9);
        press_chk(K_ENTER, 1'b1);
        chk("acc_not_latched", 64'(acc_number), 64'd0);
        press_chk(4'd9, 1'b0); press_chk(4'd9, 1'b0); press_chk(4'd9, 1'b0);
        press_chk(4'd9, 1'b0); press_chk(4'd9, 1'b1);
        press_chk(4'hE, 1'b1);
        press(K_CLEAR);
        press(4'd1); press(4'd2); press(K_ENTER);
        chk("acc_12", 64'(acc_number), 64'd12);
        press_chk(K_ENTER, 1'b1);
        press_chk(4'd5, 1'b0);
        press_chk(4'd6, 1'b1);
        press(K_ENTER);
        chk("pin_5", 64'(pin), 64'd5);
        press(4'd1); press(K_ENTER);
        chk("issue_valid_4", 64'(req_valid), 64'd1);
        chk("issue_payload_4", 64'(payload), 64'(mk(12, 5, 1, 0, 0)));

        // Asynchronous reset in the middle of an outstanding request.
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({req_valid, payload, exit, key_err}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("no_exit_on_reset", 64'(exit_count), 64'd1);
        chk("post_reset_outputs", 64'({req_valid, payload, exit, key_err}), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
